// File: rtl/tia_audio_pkg.sv
// Shared TIA audio types: AUDF value type, detector states, range limits.
// Imported by the divide-value detector and its edge-detect helper.
package tia_audio_pkg;

    localparam int TIA_AUDF_W   = 5;
    localparam int TIA_AUDF_MAX = 31;

    typedef logic [TIA_AUDF_W-1:0] audf_t;

    typedef enum logic [1:0] {
        SYNC,
        MEASURE,
        LOCKED,
        TIMEOUT
    } detect_state_e;

endpackage

// File: rtl/tia_edge_det.sv
// Toggle detector for a clk-synchronous signal, with a priming cycle.
// Ports: clk, rst (sync, active-high), sig in, toggled out (combinational).
module tia_edge_det
    import tia_audio_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic toggled
);

    logic prev;
    logic primed;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev   <= 1'b0;
            primed <= 1'b0;
        end else begin
            prev   <= sig;
            primed <= 1'b1;
        end
    end

    // prev is meaningless until it has sampled sig once after reset
    assign toggled = primed && (sig != prev);

endmodule

// File: rtl/tia_audf_detect.sv
// Recovers AUDF from the divided audio clock by timing its half-period.
// Ports: clk, rst (sync, active-high), d_clk in; audf_est, est_valid,
// locked, changed (1-cycle pulse), timeout out (all registered).
module tia_audf_detect
    import tia_audio_pkg::*;
#(
    parameter int AUDF_W     = 5,
    parameter int MAX_HALF   = 32,
    parameter int LOCK_COUNT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_clk,
    output logic [AUDF_W-1:0] audf_est,
    output logic              est_valid,
    output logic              locked,
    output logic              changed,
    output logic              timeout
);

    localparam int CW = AUDF_W + 1;
    localparam logic [CW-1:0] HALF_MAX = CW'(MAX_HALF);
    localparam logic [CW-1:0] SAT      = CW'(MAX_HALF + 1);
    localparam logic [2:0]    LC       = 3'(LOCK_COUNT);

    detect_state_e state;

    logic          toggled;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last_h;
    logic [CW-1:0] h_m1;
    logic [2:0]    match;
    logic [2:0]    match_inc;
    logic          h_eq;
    logic          to_hit;

    tia_edge_det u_edge (
        .clk     (clk),
        .rst     (rst),
        .sig     (d_clk),
        .toggled (toggled)
    );

    assign h_m1      = cnt - CW'(1);
    assign h_eq      = (cnt == last_h);
    assign match_inc = match + 3'd1;
    // An edge on the cycle cnt would saturate is a valid H=MAX_HALF
    assign to_hit    = !toggled && (cnt == HALF_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (toggled) begin
            cnt <= CW'(1);
        end else if (cnt != SAT) begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SYNC;
            audf_est  <= '0;
            est_valid <= 1'b0;
            locked    <= 1'b0;
            changed   <= 1'b0;
            timeout   <= 1'b0;
            last_h    <= '0;
            match     <= '0;
        end else begin
            changed <= 1'b0;
            unique case (state)
                SYNC: begin
                    // first interval is partial, so it is not measured
                    if (toggled) begin
                        state <= MEASURE;
                    end else if (to_hit) begin
                        state   <= TIMEOUT;
                        timeout <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (toggled) begin
                        audf_est  <= h_m1[AUDF_W-1:0];
                        est_valid <= 1'b1;
                        last_h    <= cnt;
                        if (h_eq) begin
                            match <= match_inc;
                            if (match_inc == LC) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match <= 3'd1;
                        end
                    end else if (to_hit) begin
                        state     <= TIMEOUT;
                        timeout   <= 1'b1;
                        est_valid <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (toggled && !h_eq) begin
                        changed  <= 1'b1;
                        audf_est <= h_m1[AUDF_W-1:0];
                        last_h   <= cnt;
                        match    <= 3'd1;
                        locked   <= 1'b0;
                        state    <= MEASURE;
                    end else if (to_hit) begin
                        state     <= TIMEOUT;
                        timeout   <= 1'b1;
                        est_valid <= 1'b0;
                        locked    <= 1'b0;
                    end
                end
                TIMEOUT: begin
                    // audf_est keeps its last value for readback
                    if (toggled) begin
                        state   <= MEASURE;
                        match   <= '0;
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tia_audf_detect.sv
// Directed bench for tia_audf_detect: table of divider intervals plus
// hand-written stuck-clock, reset and priming sequences.
module tb_tia_audf_detect;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_clk;
    logic [4:0] audf_est;
    logic       est_valid;
    logic       locked;
    logic       changed;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tia_audf_detect #(
        .AUDF_W     (5),
        .MAX_HALF   (32),
        .LOCK_COUNT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d_clk     (d_clk),
        .audf_est  (audf_est),
        .est_valid (est_valid),
        .locked    (locked),
        .changed   (changed),
        .timeout   (timeout)
    );

    typedef struct {
        int half;
        int edges;
        int audf;
        int valid;
        int lock;
        int chg;
        int tmo;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int a, input int v,
                           input int l, input int c, input int t);
        chk({tag, " audf_est"},  int'(audf_est), a);
        chk({tag, " est_valid"}, int'(est_valid), v);
        chk({tag, " locked"},    int'(locked), l);
        chk({tag, " changed"},   int'(changed), c);
        chk({tag, " timeout"},   int'(timeout), t);
    endtask

    // drive d_clk for one clk cycle; outputs are sampled 1ns after the edge
    task automatic cyc(input logic dv);
        d_clk = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cyc(d_clk);
    endtask

    task automatic tog();
        cyc(~d_clk);
    endtask

    initial begin
        // half-period, edges, then expected state after the last edge
        tbl[0]  = '{6,  1, 0,  0, 0, 0, 0};
        tbl[1]  = '{6,  1, 5,  1, 0, 0, 0};
        tbl[2]  = '{6,  1, 5,  1, 1, 0, 0};
        tbl[3]  = '{6,  3, 5,  1, 1, 0, 0};
        tbl[4]  = '{10, 1, 9,  1, 0, 1, 0};
        tbl[5]  = '{10, 1, 9,  1, 1, 0, 0};
        tbl[6]  = '{1,  1, 0,  1, 0, 1, 0};
        tbl[7]  = '{1,  1, 0,  1, 1, 0, 0};
        tbl[8]  = '{1,  4, 0,  1, 1, 0, 0};
        tbl[9]  = '{32, 1, 31, 1, 0, 1, 0};
        tbl[10] = '{32, 1, 31, 1, 1, 0, 0};
        tbl[11] = '{32, 2, 31, 1, 1, 0, 0};
        tbl[12] = '{8,  1, 7,  1, 0, 1, 0};
        tbl[13] = '{8,  1, 7,  1, 1, 0, 0};

        rst   = 1'b1;
        d_clk = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        chk_out("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int r = 0; r < 14; r++) begin
            for (int e = 0; e < tbl[r].edges; e++) begin
                for (int h = 0; h < tbl[r].half - 1; h++) begin
                    cyc(d_clk);
                    chk($sformatf("vec%0d hold changed", r), int'(changed), 0);
                    chk($sformatf("vec%0d hold timeout", r), int'(timeout), 0);
                end
                tog();
            end
            chk_out($sformatf("vec%0d", r), tbl[r].audf, tbl[r].valid,
                    tbl[r].lock, tbl[r].chg, tbl[r].tmo);
        end

        // stuck clock after lock at AUDF=7
        hold(31);
        chk("stuck 32 cyc timeout", int'(timeout), 0);
        hold(1);
        chk_out("stuck 33 cyc", 7, 0, 0, 0, 1);
        hold(5);
        chk("stuck hold timeout", int'(timeout), 1);
        tog();
        chk_out("restart edge1", 7, 0, 0, 0, 0);
        hold(3);
        tog();
        chk_out("restart edge2", 3, 1, 0, 0, 0);
        hold(3);
        tog();
        chk_out("restart edge3", 3, 1, 1, 0, 0);

        // reset mid-interval while locked
        hold(2);
        rst = 1'b1;
        cyc(d_clk);
        chk_out("mid reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(d_clk);
        hold(2);
        tog();
        chk_out("post reset edge1", 0, 0, 0, 0, 0);
        hold(3);
        tog();
        chk_out("post reset edge2", 3, 1, 0, 0, 0);
        hold(3);
        tog();
        chk_out("post reset edge3", 3, 1, 1, 0, 0);

        // release reset with d_clk high: priming cycle must not count
        rst = 1'b1;
        cyc(1'b1);
        rst = 1'b0;
        cyc(1'b1);
        chk("prime d_clk=1 valid", int'(est_valid), 0);
        hold(4);
        cyc(1'b0);
        chk_out("prime first edge", 0, 0, 0, 0, 0);
        hold(5);
        cyc(1'b1);
        chk_out("prime second edge", 5, 1, 0, 0, 0);

        // no edges at all after reset
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        hold(20);
        chk("sync idle timeout", int'(timeout), 0);
        hold(20);
        chk_out("sync dead clock", 0, 0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tia_audf_detect.md
# tia_audf_detect

Recovers the 5-bit AUDF divide value from the TIA audio divided clock. It is the receiving end of the divide-by-N stage: the divider toggles `d_clk` every AUDF+1 `clk` cycles; this block measures the half-period and reports AUDF, lock status and dead-clock timeout. It sits on the audio clock domain beside the divider and feeds the verification scoreboard and debug register readback.

## Interface
- `AUDF_W`, default 5: width of the recovered divide value.
- `MAX_HALF`, default 32: longest legal half-period in cycles, equal to 2^AUDF_W.
- `LOCK_COUNT`, default 2: number of consecutive identical measurements needed to assert lock. Legal range is 2..7.
- `clk`, input, 1: audio clock, the same clock that drives the divider.
- `rst`, input, 1: reset, synchronous and active-high.
- `d_clk`, input, 1: divided clock under measurement. It is synchronous to `clk`, so no synchronizer is used.
- `audf_est`, output, AUDF_W: recovered AUDF, equal to half-period minus 1.
- `est_valid`, output, 1: `audf_est` holds a measurement from a complete interval.
- `locked`, output, 1: the last LOCK_COUNT measurements were identical.
- `changed`, output, 1: one-cycle pulse when a measurement differs while `locked` is set.
- `timeout`, output, 1: no edge has been seen for MAX_HALF+1 cycles.

## Operation
- **Edge detect:** `prev` is `d_clk` delayed one cycle. `edge` = (`d_clk` != `prev`), evaluated only after the priming cycle. In the first cycle after reset, `prev` loads `d_clk` and no edge is reported.
- **Counter `cnt`:** width AUDF_W+1, saturating at MAX_HALF+1.
  - On an edge, `cnt` is set to 1.
  - Otherwise `cnt` increments.
  - On an edge, the measured half-period is H = `cnt` (the value before update). H is always in 1..MAX_HALF.
- **Estimate:** `audf_est` = H−1, truncated to AUDF_W bits.
- **Lock tracking:** `last_h` holds the previous measurement. `match` (3 bits) counts consecutive equal measurements.
- **States** (all transitions and the same-cycle actions below are registered):
  - **SYNC** (reset state). Wait for the first edge.
    - Edge → MEASURE. Set `cnt`=1; no measurement is taken (the interval is partial).
    - `cnt` reaches MAX_HALF+1 → TIMEOUT.
  - **MEASURE.** On each edge:
    - Load `audf_est`, set `est_valid`=1.
    - If H == `last_h`, `match`++; otherwise `match`=1.
    - Load `last_h`=H.
    - Go to LOCKED when `match` reaches LOCK_COUNT.
    - `cnt` reaches MAX_HALF+1 → TIMEOUT.
  - **LOCKED.** `locked`=1.
    - Edge with H == `last_h`: `audf_est` is unchanged.
    - Edge with H != `last_h`: pulse `changed`, load the new estimate, set `match`=1, clear `locked`, go to MEASURE.
    - `cnt` reaches MAX_HALF+1 → TIMEOUT.
  - **TIMEOUT.**
    - Outputs: `timeout`=1, `est_valid`=0, `locked`=0. `audf_est` holds its last value.
    - Next edge → MEASURE. Set `cnt`=1, `match`=0, take no measurement, clear `timeout`.
- **Simultaneous events:** an edge in the same cycle `cnt` would reach MAX_HALF+1 is a valid H=MAX_HALF measurement. The edge wins and no timeout occurs.
- **Reset:** a reset mid-operation returns the block to SYNC on the next edge of `clk`. All history (`match`, `last_h`, `cnt`, `prev` priming) is discarded.

## Timing
- **Reset values:** `audf_est`=0, `est_valid`=0, `locked`=0, `changed`=0, `timeout`=0, state=SYNC.
- **Measurement latency:** `d_clk` changes in cycle t; the edge is detected in cycle t when comparing against `prev`; outputs update visibly at t+1.
- **Time to first valid estimate:** 2 edges after SYNC.
- **Time to lock:** LOCK_COUNT+1 edges after SYNC, when the period is stable.
- **`timeout` assertion:** visible MAX_HALF+1 cycles after the last edge.
- **`changed`:** high for exactly 1 cycle and never asserted outside LOCKED.

## Structure
- **Shared package `tia_audio_pkg`:**
  - `audf_t` (logic [AUDF_W-1:0]), the AUDF type.
  - `detect_state_e`: SYNC, MEASURE, LOCKED, TIMEOUT.
  - Localparam `TIA_AUDF_MAX` = 31.
- **Sub-module `tia_edge_det`:** holds the priming flag and `prev` register, and outputs `edge`. It is reusable by other TIA channel monitors.
- **Top level:** one FSM, the counter, and the lock comparator.

## Test plan
- **Stable mid-range period:** divider with AUDF=5 (toggle every 6 cycles) → `est_valid` after 2nd edge with `audf_est`=5; `locked` after 3rd edge; `changed`/`timeout` stay 0.
- **Range extremes:**
  - AUDF=0 (toggle every cycle) → `audf_est`=0, lock.
  - AUDF=31 (H=32) → `audf_est`=31, no `timeout` ever.
- **Period change while locked:** lock at AUDF=5, switch to AUDF=9 → one-cycle `changed` on the first 10-cycle interval, `locked` drops, `audf_est`=9, relock after one more 10-cycle interval.
- **Stuck clock:** hold `d_clk` low → `timeout` 33 cycles after last edge, `est_valid`=0. Restarting at AUDF=3 → `timeout` clears on first edge, `audf_est`=3 after the next edge.
- **Reset mid-operation:** assert `rst` mid-interval while locked → all outputs 0 next cycle. First edge after reset is not measured; no false `changed`.
- **Reset with `d_clk`=1:** release `rst` while `d_clk`=1 → no spurious edge on the priming cycle.
